// File: rtl/muldiv_sequencer_if.sv
// HI/LO unit bus: core-side requests in, status and HI/LO out.
// With MULDIV_DIV0_FLAG_EN defined, the bus also carries the div0 flag.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  enable;
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  hilo_write_en;
  logic                  hilo_write_sel;
  logic [DATA_WIDTH-1:0] hilo_write_data;
  logic                  read_req;
  logic                  busy;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic                  div0;

  modport master (
    output enable, start, op, operand_a, operand_b,
           hilo_write_en, hilo_write_sel, hilo_write_data, read_req,
    input  busy, stall, done, hi, lo, div0
  );
  modport slave (
    input  enable, start, op, operand_a, operand_b,
           hilo_write_en, hilo_write_sel, hilo_write_data, read_req,
    output busy, stall, done, hi, lo, div0
  );
`else
  modport master (
    output enable, start, op, operand_a, operand_b,
           hilo_write_en, hilo_write_sel, hilo_write_data, read_req,
    input  busy, stall, done, hi, lo
  );
  modport slave (
    input  enable, start, op, operand_a, operand_b,
           hilo_write_en, hilo_write_sel, hilo_write_data, read_req,
    output busy, stall, done, hi, lo
  );
`endif
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide sequencer that owns HI/LO.
// Optional macro MULDIV_DIV0_FLAG_EN adds a div0 pulse alongside done.
//
// state | meaning
// IDLE  | waiting; accepts start, or MTHI/MTLO when no start
// RUN   | one multiply or divide iteration per enabled edge
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]              r_state;
  logic [CW-1:0]           r_count;
  logic [DATA_WIDTH-1:0]   r_opnd;
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic                    r_is_div;
  logic                    r_neg_lo;
  logic                    r_neg_hi;
  logic                    r_b_zero;
  logic [DATA_WIDTH-1:0]   r_hi;
  logic [DATA_WIDTH-1:0]   r_lo;
  logic                    r_done;
`ifdef MULDIV_DIV0_FLAG_EN
  logic                    r_div0;
`endif

  logic                    w_a_neg;
  logic                    w_b_neg;
  logic [DATA_WIDTH-1:0]   w_a_mag;
  logic [DATA_WIDTH-1:0]   w_b_mag;
  logic [DATA_WIDTH-1:0]   w_addend;
  logic [DATA_WIDTH:0]     w_add_sum;
  logic [2*DATA_WIDTH-1:0] w_mul_next;
  logic [DATA_WIDTH:0]     w_rem_sh;
  logic [DATA_WIDTH:0]     w_trial;
  logic [2*DATA_WIDTH-1:0] w_div_next;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quo;
  logic [DATA_WIDTH-1:0]   w_rem;

  // Signed ops are MULT (00) and DIV (10): op[0] clear.
  always_comb begin
    w_a_neg = ~bus.op[0] & bus.operand_a[DATA_WIDTH-1];
    w_b_neg = ~bus.op[0] & bus.operand_b[DATA_WIDTH-1];
    w_a_mag = w_a_neg ? -bus.operand_a : bus.operand_a;
    w_b_mag = w_b_neg ? -bus.operand_b : bus.operand_b;
  end

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right with carry.
  always_comb begin
    w_addend   = r_acc[0] ? r_opnd : '0;
    w_add_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, w_addend};
    w_mul_next = {w_add_sum, r_acc[DATA_WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; borrow out of w_trial means restore.
  always_comb begin
    w_rem_sh = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, r_opnd};
    if (w_trial[DATA_WIDTH])
      w_div_next = {w_rem_sh[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0};
    else
      w_div_next = {w_trial[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
  end

  // A zero divisor leaves |dividend| in the remainder, so HI comes back as operand_a.
  always_comb begin
    w_prod = r_neg_lo ? -r_acc : r_acc;
    w_quo  = r_b_zero ? '1
           : (r_neg_lo ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0]);
    w_rem  = r_neg_hi ? -r_acc[2*DATA_WIDTH-1:DATA_WIDTH]
                      : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_b_zero <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      r_div0   <= 1'b0;
`endif
    end else if (bus.enable) begin
      r_done <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      r_div0 <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_is_div <= bus.op[1];
            r_b_zero <= (bus.operand_b == '0);
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_count  <= COUNT_INIT;
            r_state  <= RUN;
            if (bus.op[1]) begin
              r_opnd <= w_b_mag;
              r_acc  <= {{DATA_WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_opnd <= w_a_mag;
              r_acc  <= {{DATA_WIDTH{1'b0}}, w_b_mag};
            end
          end else if (bus.hilo_write_en) begin
            if (bus.hilo_write_sel)
              r_hi <= bus.hilo_write_data;
            else
              r_lo <= bus.hilo_write_data;
          end
        end
        RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_count == '0)
            r_state <= FIX;
          else
            r_count <= r_count - 1'b1;
        end
        FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            r_lo <= w_prod[DATA_WIDTH-1:0];
          end
          r_done  <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
          r_div0  <= r_is_div & r_b_zero;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (r_state != IDLE);
  assign bus.stall = bus.busy & (bus.start | bus.read_req | bus.hilo_write_en);
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
`ifdef MULDIV_DIV0_FLAG_EN
  assign bus.div0  = r_div0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus stall/reset/enable sequences.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;

  muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();
  muldiv_sequencer #(.DATA_WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic issue_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges from now until done is seen; 200 means it never came.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1 n++;
    end while (!bus.done && n < 200);
  endtask

  initial begin
    int n;
    int m;
    int stall_cnt;
    n_vec  = 0;
    n_miss = 0;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{OP_MULT,  32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0};

    reset               = 1'b1;
    bus.enable          = 1'b1;
    bus.start           = 1'b0;
    bus.op              = OP_MULT;
    bus.operand_a       = '0;
    bus.operand_b       = '0;
    bus.hilo_write_en   = 1'b0;
    bus.hilo_write_sel  = 1'b0;
    bus.hilo_write_data = '0;
    bus.read_req        = 1'b0;

    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset stall", 64'(bus.stall), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // MTHI then MTLO, one edge each
    @(negedge clock);
    bus.hilo_write_en   = 1'b1;
    bus.hilo_write_sel  = 1'b1;
    bus.hilo_write_data = 32'hA5A5A5A5;
    check("mthi before edge", 64'(bus.hi), 64'd0);
    @(posedge clock);
    #1;
    check("mthi hi", 64'(bus.hi), 64'hA5A5A5A5);
    check("mthi lo untouched", 64'(bus.lo), 64'd0);
    bus.hilo_write_sel  = 1'b0;
    bus.hilo_write_data = 32'h5A5A1234;
    @(posedge clock);
    #1;
    check("mtlo lo", 64'(bus.lo), 64'h5A5A1234);
    check("mtlo hi kept", 64'(bus.hi), 64'hA5A5A5A5);
    bus.hilo_write_en = 1'b0;

    // start wins over a same-cycle MTHI
    @(negedge clock);
    bus.start           = 1'b1;
    bus.op              = OP_MULTU;
    bus.operand_a       = 32'd2;
    bus.operand_b       = 32'd3;
    bus.hilo_write_en   = 1'b1;
    bus.hilo_write_sel  = 1'b1;
    bus.hilo_write_data = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    bus.start         = 1'b0;
    bus.hilo_write_en = 1'b0;
    check("prio busy", 64'(bus.busy), 64'd1);
    check("prio hi not written", 64'(bus.hi), 64'hA5A5A5A5);
    wait_done(n);
    check("prio latency", 64'(n), 64'd33);
    check("prio lo", 64'(bus.lo), 64'd6);

    for (int i = 0; i < 12; i++) begin
      issue_start(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(n);
      check($sformatf("v%0d latency", i), 64'(n), 64'd33);
      check($sformatf("v%0d hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      check($sformatf("v%0d lo", i), 64'(bus.lo), 64'(vecs[i].lo));
      check($sformatf("v%0d busy", i), 64'(bus.busy), 64'd0);
`ifdef MULDIV_DIV0_FLAG_EN
      check($sformatf("v%0d div0", i), 64'(bus.div0), 64'(vecs[i].dz));
`endif
      @(posedge clock);
      #1;
      check($sformatf("v%0d done pulse", i), 64'(bus.done), 64'd0);
`ifdef MULDIV_DIV0_FLAG_EN
      check($sformatf("v%0d div0 pulse", i), 64'(bus.div0), 64'd0);
`endif
    end

    // read_req held from the edge after start: stall for 32 cycles, clear when done
    issue_start(OP_MULTU, 32'd3, 32'd5);
    @(posedge clock);
    #1 bus.read_req = 1'b1;
    n = 1;
    stall_cnt = 0;
    while (!bus.done && n < 200) begin
      @(negedge clock);
      if (bus.stall) stall_cnt++;
      @(posedge clock);
      #1 n++;
    end
    check("rd latency", 64'(n), 64'd33);
    check("rd stall cycles", 64'(stall_cnt), 64'd32);
    check("rd stall at done", 64'(bus.stall), 64'd0);
    check("rd lo", 64'(bus.lo), 64'd15);
    bus.read_req = 1'b0;

    // second start while busy is held off until IDLE
    issue_start(OP_MULTU, 32'd3, 32'd5);
    bus.start     = 1'b1;
    bus.op        = OP_DIVU;
    bus.operand_a = 32'd100;
    bus.operand_b = 32'd7;
    #1;
    check("s2 stall busy", 64'(bus.stall), 64'd1);
    wait_done(n);
    check("s2 first latency", 64'(n), 64'd33);
    check("s2 first lo", 64'(bus.lo), 64'd15);
    check("s2 stall idle", 64'(bus.stall), 64'd0);
    @(posedge clock);
    #1 bus.start = 1'b0;
    check("s2 second busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    check("s2 second latency", 64'(n), 64'd33);
    check("s2 second hi", 64'(bus.hi), 64'd2);
    check("s2 second lo", 64'(bus.lo), 64'd14);

    // reset ten cycles into a MULT aborts it
    issue_start(OP_MULT, 32'd6, 32'd7);
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hi", 64'(bus.hi), 64'd0);
    check("abort lo", 64'(bus.lo), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("abort stays idle", 64'(bus.busy), 64'd0);

    // enable low for 5 edges mid-run stretches latency by 5
    issue_start(OP_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #1 bus.enable = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("frozen busy", 64'(bus.busy), 64'd1);
    check("frozen done", 64'(bus.done), 64'd0);
    bus.enable = 1'b1;
    wait_done(m);
    check("frozen latency", 64'(15 + m), 64'd38);
    check("frozen hi", 64'(bus.hi), 64'd1);
    check("frozen lo", 64'(bus.lo), 64'd333);

    // enable low also holds the done pulse
    bus.enable = 1'b0;
    @(posedge clock);
    #1;
    check("frozen done held", 64'(bus.done), 64'd1);
    bus.enable = 1'b1;
    @(posedge clock);
    #1;
    check("done cleared", 64'(bus.done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle HI/LO unit controller for the single-cycle MIPS core. It replaces the combinational Multiplier/Divider + HI/LO register pair with one shared iterative shift-add / restoring-divide datapath. The sequencer owns HI and LO, runs one iteration per clock, and raises stall to the core on structural or read-after-write hazards against HI/LO. It sits between the controller decode (mult/div/MTHI/MTLO/MFHI/MFLO) and the register file write-back mux.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  global enable; low freezes every register, including done.
start  input  1  request a new mult/div operation.
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
operand_a  input  DATA_WIDTH  multiplicand / dividend (rs).
operand_b  input  DATA_WIDTH  multiplier / divisor (rt).
hilo_write_en  input  1  MTHI/MTLO request.
hilo_write_sel  input  1  0 = LO, 1 = HI.
hilo_write_data  input  DATA_WIDTH  MTHI/MTLO data.
read_req  input  1  MFHI/MFLO in decode.
busy  output  1  state != IDLE.
stall  output  1  core must hold PC and the current instruction.
done  output  1  one-cycle pulse; HI/LO just updated by an operation.
hi  output  DATA_WIDTH  HI register.
lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (async): state IDLE, hi = 0, lo = 0, done = 0, counter = 0, internal accumulators = 0. Reset mid-operation aborts it; HI/LO are cleared, not partially written.
- Interface clocking: clock on rising edge; reset is asynchronous and active-high.
- FSM states: IDLE, RUN, FIX.
- IDLE, start & enable: latch |a| and |b| for signed ops (raw values for unsigned), latch result signs, counter = DATA_WIDTH-1, go to RUN.
- RUN: one iteration per edge. Multiply uses a 2*DATA_WIDTH shift-add accumulator. Divide uses restoring division: shift the remainder left, trial-subtract the divisor, shift the quotient bit in. Counter == 0 on an edge -> FIX.
- FIX: apply sign correction, write HI/LO, done <= 1 for one cycle, go to IDLE.
- Latency: the start-sampling edge is E0. HI/LO hold the result after edge E0 + DATA_WIDTH + 1 (33 for 32). done is high during the cycle that follows that edge.
- Sign rules:
  - Signed product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - All arithmetic is modulo 2^DATA_WIDTH per register.
  - MULT/MULTU: HI = upper half, LO = lower half.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Overflow case most-negative / -1: LO = 0x80000000, HI = 0.
- Divide by zero: LO = all-ones, HI = operand_a (original, unmodified), for both DIV and DIVU. The operation still takes full latency.
- hilo_write_en in IDLE: the selected register is written at the next edge, 1-cycle effect.
- stall = busy & (start | read_req | hilo_write_en), combinational. A stalled request is not consumed; the core re-presents it.
- start, read_req and hilo_write_en in the same cycle while IDLE is illegal (single issue). The bench does not drive it.
- Same-cycle priority in IDLE: start > hilo_write_en.
- done is cleared on any enabled edge where it is not being set.
- enable low: all state and counter frozen. stall still computed from current state.

Optional Feature:
MULDIV_DIV0_FLAG_EN
- Defined: adds output div0 (1 bit, reset 0). It pulses together with done when a DIV/DIVU completes with operand_b == 0, otherwise 0.
- Undefined: port absent; divide-by-zero results unchanged.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 edges HI = 0xFFFFFFFE, LO = 0x00000001; done one cycle; busy low afterwards.
- MULT -3 × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2.
- read_req held from 1 cycle after start -> stall high for 32 cycles, low in the cycle done is high; a second start while busy stalls and starts only after IDLE.
- DIVU 0x1234 / 0 -> LO = 0xFFFFFFFF, HI = 0x1234; with MULDIV_DIV0_FLAG_EN, div0 pulses with done. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- MTHI 0xA5A5A5A5 in IDLE -> hi updates next edge. Reset asserted 10 cycles into a MULT -> busy = 0, hi = lo = 0, done = 0 immediately. enable low for 5 cycles mid-run -> latency extends by exactly 5.
